// File: rtl/nasti_lite_master_bridge.sv
// Single-outstanding NASTI-Lite initiator: turns a local request/response port into one
// AR/R read or AW/W/B write at a time. All handshake and response outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready high, waiting for a local request
// RD_ADDR | ar_valid high with latched address, waiting for ar_ready
// RD_DATA | r_ready high, waiting for r_valid
// WR_REQ  | AW and W outstanding, each retired independently
// WR_RESP | b_ready high, waiting for b_valid
// RESP    | rsp_valid held with data/error until rsp_ready
module nasti_lite_master_bridge #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    s_nasti_aclk,
    input  logic                    s_nasti_aresetn,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic [ID_WIDTH-1:0]     m_nasti_aw_id,
    output logic [ADDR_WIDTH-1:0]   m_nasti_aw_addr,
    output logic [7:0]              m_nasti_aw_len,
    output logic [2:0]              m_nasti_aw_size,
    output logic [1:0]              m_nasti_aw_burst,
    output logic                    m_nasti_aw_lock,
    output logic [3:0]              m_nasti_aw_cache,
    output logic [2:0]              m_nasti_aw_prot,
    output logic [3:0]              m_nasti_aw_qos,
    output logic [3:0]              m_nasti_aw_region,
    output logic                    m_nasti_aw_valid,
    input  logic                    m_nasti_aw_ready,

    output logic [DATA_WIDTH-1:0]   m_nasti_w_data,
    output logic [DATA_WIDTH/8-1:0] m_nasti_w_strb,
    output logic                    m_nasti_w_last,
    output logic                    m_nasti_w_valid,
    input  logic                    m_nasti_w_ready,

    input  logic [ID_WIDTH-1:0]     m_nasti_b_id,
    input  logic [1:0]              m_nasti_b_resp,
    input  logic                    m_nasti_b_valid,
    output logic                    m_nasti_b_ready,

    output logic [ID_WIDTH-1:0]     m_nasti_ar_id,
    output logic [ADDR_WIDTH-1:0]   m_nasti_ar_addr,
    output logic [7:0]              m_nasti_ar_len,
    output logic [2:0]              m_nasti_ar_size,
    output logic [1:0]              m_nasti_ar_burst,
    output logic                    m_nasti_ar_lock,
    output logic [3:0]              m_nasti_ar_cache,
    output logic [2:0]              m_nasti_ar_prot,
    output logic [3:0]              m_nasti_ar_qos,
    output logic [3:0]              m_nasti_ar_region,
    output logic                    m_nasti_ar_valid,
    input  logic                    m_nasti_ar_ready,

    input  logic [ID_WIDTH-1:0]     m_nasti_r_id,
    input  logic [DATA_WIDTH-1:0]   m_nasti_r_data,
    input  logic [1:0]              m_nasti_r_resp,
    input  logic                    m_nasti_r_last,
    input  logic                    m_nasti_r_valid,
    output logic                    m_nasti_r_ready
);

    localparam int          STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  BEAT_SIZE  = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    r_ready_q, r_ready_d;
    logic                    b_ready_q, b_ready_d;

    // A write channel is finished once its valid has dropped or is handshaking now.
    logic aw_fin, w_fin;
    assign aw_fin = !aw_valid_q || m_nasti_aw_ready;
    assign w_fin  = !w_valid_q  || m_nasti_w_ready;

    logic unused_slave_fields;
    assign unused_slave_fields = ^{m_nasti_b_resp[0], m_nasti_r_resp[0], m_nasti_r_last,
                                   m_nasti_b_id, m_nasti_r_id};

    always_ff @(posedge s_nasti_aclk or negedge s_nasti_aresetn) begin
        if (!s_nasti_aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            b_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ar_valid_q  <= ar_valid_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            r_ready_q   <= r_ready_d;
            b_ready_q   <= b_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ar_valid_d  = ar_valid_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        r_ready_d   = r_ready_q;
        b_ready_d   = b_ready_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    req_ready_d = 1'b0;
                    if (req_we) begin
                        wdata_d    = req_wdata;
                        wstrb_d    = req_wstrb;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_ADDR;
                    end
                end
            end

            RD_ADDR: begin
                if (m_nasti_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RD_DATA;
                end
            end

            RD_DATA: begin
                if (m_nasti_r_valid) begin
                    rsp_rdata_d = m_nasti_r_data;
                    rsp_err_d   = m_nasti_r_resp[1];
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end

            WR_REQ: begin
                aw_valid_d = aw_valid_q && !m_nasti_aw_ready;
                w_valid_d  = w_valid_q  && !m_nasti_w_ready;
                if (aw_fin && w_fin) begin
                    b_ready_d = 1'b1;
                    state_d   = WR_RESP;
                end
            end

            WR_RESP: begin
                if (m_nasti_b_valid) begin
                    rsp_err_d   = m_nasti_b_resp[1];
                    rsp_rdata_d = '0;
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign m_nasti_aw_id     = '0;
    assign m_nasti_aw_addr   = addr_q;
    assign m_nasti_aw_len    = 8'd0;
    assign m_nasti_aw_size   = BEAT_SIZE;
    assign m_nasti_aw_burst  = BURST_INCR;
    assign m_nasti_aw_lock   = 1'b0;
    assign m_nasti_aw_cache  = 4'd0;
    assign m_nasti_aw_prot   = 3'd0;
    assign m_nasti_aw_qos    = 4'd0;
    assign m_nasti_aw_region = 4'd0;
    assign m_nasti_aw_valid  = aw_valid_q;

    assign m_nasti_w_data    = wdata_q;
    assign m_nasti_w_strb    = wstrb_q;
    assign m_nasti_w_last    = 1'b1;
    assign m_nasti_w_valid   = w_valid_q;

    assign m_nasti_b_ready   = b_ready_q;

    assign m_nasti_ar_id     = '0;
    assign m_nasti_ar_addr   = addr_q;
    assign m_nasti_ar_len    = 8'd0;
    assign m_nasti_ar_size   = BEAT_SIZE;
    assign m_nasti_ar_burst  = BURST_INCR;
    assign m_nasti_ar_lock   = 1'b0;
    assign m_nasti_ar_cache  = 4'd0;
    assign m_nasti_ar_prot   = 3'd0;
    assign m_nasti_ar_qos    = 4'd0;
    assign m_nasti_ar_region = 4'd0;
    assign m_nasti_ar_valid  = ar_valid_q;

    assign m_nasti_r_ready   = r_ready_q;

endmodule
